// File: rtl/ddr_cmd_pkg.sv
// ============================================================================
// Module : ddr_cmd_pkg
// Brief  : Command encodings, pin patterns and counter sizing for the DDR3
//          command issue stage.
// Rev    : 1.0
// ============================================================================
`default_nettype none

`ifndef MEM_ROW_WIDTH
`define MEM_ROW_WIDTH 14
`endif
`ifndef MEM_BA_WIDTH
`define MEM_BA_WIDTH 3
`endif

package ddr_cmd_pkg;

    typedef enum logic [2:0] {
        CMD_NOP = 3'd0,
        CMD_ACT = 3'd1,
        CMD_RD  = 3'd2,
        CMD_WR  = 3'd3,
        CMD_PRE = 3'd4,
        CMD_REF = 3'd5,
        CMD_MRS = 3'd6
    } ddr_cmd_e;

    typedef enum logic {
        BANK_IDLE   = 1'b0,
        BANK_ACTIVE = 1'b1
    } bank_state_e;

    // {cs_n, ras_n, cas_n, we_n}
    localparam logic [3:0] PIN_DESEL = 4'b1111;
    localparam logic [3:0] PIN_NOP   = 4'b0111;
    localparam logic [3:0] PIN_ACT   = 4'b0011;
    localparam logic [3:0] PIN_RD    = 4'b0101;
    localparam logic [3:0] PIN_WR    = 4'b0100;
    localparam logic [3:0] PIN_PRE   = 4'b0010;
    localparam logic [3:0] PIN_REF   = 4'b0001;
    localparam logic [3:0] PIN_MRS   = 4'b0000;

    function automatic int imax(input int x, input int y);
        return (x > y) ? x : y;
    endfunction

    function automatic int cnt_width(input int t_max);
        return $clog2(t_max) + 1;
    endfunction

    function automatic logic [3:0] cmd_pins(input ddr_cmd_e cmd);
        case (cmd)
            CMD_ACT: return PIN_ACT;
            CMD_RD:  return PIN_RD;
            CMD_WR:  return PIN_WR;
            CMD_PRE: return PIN_PRE;
            CMD_REF: return PIN_REF;
            CMD_MRS: return PIN_MRS;
            default: return PIN_NOP;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/ddr_bank_timer.sv
// ============================================================================
// Module : ddr_bank_timer
// Brief  : One bank's IDLE/ACTIVE state with its tRCD, tRAS and tRP counters.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module ddr_bank_timer
    import ddr_cmd_pkg::*;
#(
    parameter int CW    = 7,
    parameter int T_RCD = 5,
    parameter int T_RP  = 5,
    parameter int T_RAS = 15
) (
    input  logic ck_t,
    input  logic reset,
    input  logic act,
    input  logic pre,
    output logic can_act,
    output logic can_col,
    output logic can_pre,
    output logic is_active
);

    bank_state_e   r_state;
    logic [CW-1:0] r_rcd;
    logic [CW-1:0] r_ras;
    logic [CW-1:0] r_rp;

    always_ff @(posedge ck_t) begin
        if (reset) begin
            r_state <= BANK_IDLE;
            r_rcd   <= '0;
            r_ras   <= '0;
            r_rp    <= '0;
        end else begin
            if (r_rcd != '0) r_rcd <= r_rcd - 1'b1;
            if (r_ras != '0) r_ras <= r_ras - 1'b1;
            if (r_rp  != '0) r_rp  <= r_rp  - 1'b1;
            if (act) begin
                r_state <= BANK_ACTIVE;
                r_rcd   <= CW'(T_RCD - 1);
                r_ras   <= CW'(T_RAS - 1);
            end else if (pre) begin
                r_state <= BANK_IDLE;
                r_rp    <= CW'(T_RP - 1);
            end
        end
    end

    assign is_active = (r_state == BANK_ACTIVE);
    assign can_act   = (r_state == BANK_IDLE) && (r_rp == '0);
    assign can_col   = (r_state == BANK_ACTIVE) && (r_rcd == '0);
    assign can_pre   = (r_ras == '0);

endmodule

`default_nettype wire

// File: rtl/ddr_cmd_issuer.sv
// ============================================================================
// Module : ddr_cmd_issuer
// Brief  : DDR3 command issue stage: bank tracking, timing checks, pin drive.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module ddr_cmd_issuer
    import ddr_cmd_pkg::*;
#(
    parameter int ROW_W        = `MEM_ROW_WIDTH,
    parameter int BA_W         = `MEM_BA_WIDTH,
    parameter int T_RCD        = 5,
    parameter int T_RP         = 5,
    parameter int T_RAS        = 15,
    parameter int T_CCD        = 4,
    parameter int T_RFC        = 44,
    parameter int T_MRD        = 4,
    parameter int INIT_CKE_LOW = 8,
    parameter int ODT_LEN      = 6
) (
    input  logic             ck_t,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  ddr_cmd_e         req_cmd,
    input  logic [BA_W-1:0]  req_ba,
    input  logic [ROW_W-1:0] req_addr,
    output logic             cke,
    output logic             cs_n,
    output logic             ras_n,
    output logic             cas_n,
    output logic             we_n,
    output logic [ROW_W-1:0] a,
    output logic [BA_W-1:0]  ba,
    output logic             odt,
    output logic             err_illegal
);

    localparam int NUM_BANKS = 2 ** BA_W;
    localparam int T_MAX = imax(imax(imax(T_RCD, T_RP), imax(T_RAS, T_CCD)),
                                imax(imax(T_RFC, T_MRD), imax(INIT_CKE_LOW, ODT_LEN)));
    localparam int CW = cnt_width(T_MAX);

    logic [CW-1:0]    r_ccd, r_rfc, r_mrd, r_init_cnt, r_odt_cnt;
    logic             r_init_done, r_cke, r_odt, r_err;
    logic [3:0]       r_pins;
    logic [ROW_W-1:0] r_a;
    logic [BA_W-1:0]  r_ba;

    logic [NUM_BANKS-1:0] w_act, w_pre, w_can_act, w_can_col, w_can_pre, w_is_active;
    logic w_legal, w_timing_ok, w_fire, w_issue, w_pre_all;
    logic w_all_idle, w_all_rp_ok, w_pre_all_ok;

    assign w_pre_all    = req_addr[10];
    assign w_all_idle   = ~|w_is_active;
    assign w_all_rp_ok  = &w_can_act;
    assign w_pre_all_ok = &(~w_is_active | w_can_pre);

    always_comb begin
        w_legal     = 1'b0;
        w_timing_ok = 1'b0;
        case (req_cmd)
            CMD_NOP: begin
                w_legal     = 1'b1;
                w_timing_ok = 1'b1;
            end
            CMD_ACT: begin
                w_legal     = !w_is_active[req_ba];
                w_timing_ok = w_can_act[req_ba];
            end
            CMD_RD, CMD_WR: begin
                w_legal     = w_is_active[req_ba];
                w_timing_ok = w_can_col[req_ba] && (r_ccd == '0);
            end
            CMD_PRE: begin
                w_legal     = 1'b1;
                w_timing_ok = w_pre_all ? w_pre_all_ok : w_can_pre[req_ba];
            end
            CMD_REF: begin
                w_legal     = w_all_idle;
                w_timing_ok = w_all_rp_ok;
            end
            CMD_MRS: begin
                w_legal     = w_all_idle;
                w_timing_ok = 1'b1;
            end
            default: begin
                w_legal     = 1'b0;
                w_timing_ok = 1'b0;
            end
        endcase
    end

    // Illegal commands are swallowed only once all global gaps have elapsed.
    assign req_ready = r_init_done &&
                       ((req_cmd == CMD_NOP) ||
                        ((r_rfc == '0) && (r_mrd == '0) &&
                         (w_legal ? w_timing_ok : (r_ccd == '0))));
    assign w_fire  = req_valid && req_ready;
    assign w_issue = w_fire && w_legal && (req_cmd != CMD_NOP);

    for (genvar i = 0; i < NUM_BANKS; i++) begin : g_bank
        assign w_act[i] = w_issue && (req_cmd == CMD_ACT) && (req_ba == BA_W'(i));
        assign w_pre[i] = w_issue && (req_cmd == CMD_PRE) && (w_pre_all || (req_ba == BA_W'(i)));

        ddr_bank_timer #(
            .CW    (CW),
            .T_RCD (T_RCD),
            .T_RP  (T_RP),
            .T_RAS (T_RAS)
        ) u_bank (
            .ck_t      (ck_t),
            .reset     (reset),
            .act       (w_act[i]),
            .pre       (w_pre[i]),
            .can_act   (w_can_act[i]),
            .can_col   (w_can_col[i]),
            .can_pre   (w_can_pre[i]),
            .is_active (w_is_active[i])
        );
    end

    always_ff @(posedge ck_t) begin
        if (reset) begin
            r_init_cnt  <= '0;
            r_init_done <= 1'b0;
            r_cke       <= 1'b0;
            r_pins      <= PIN_DESEL;
            r_a         <= '0;
            r_ba        <= '0;
            r_odt       <= 1'b0;
            r_odt_cnt   <= '0;
            r_err       <= 1'b0;
            r_ccd       <= '0;
            r_rfc       <= '0;
            r_mrd       <= '0;
        end else begin
            r_err <= 1'b0;
            if (!r_init_done) begin
                if (r_init_cnt == CW'(INIT_CKE_LOW - 1)) begin
                    r_init_done <= 1'b1;
                    r_cke       <= 1'b1;
                    r_pins      <= PIN_NOP;
                end else begin
                    r_init_cnt <= r_init_cnt + 1'b1;
                end
            end else begin
                r_pins <= PIN_NOP;
                if (w_issue) begin
                    r_pins <= cmd_pins(req_cmd);
                    r_a    <= req_addr;
                    r_ba   <= req_ba;
                end
                r_err <= w_fire && !w_legal;
            end

            if (w_issue && (req_cmd == CMD_RD || req_cmd == CMD_WR)) r_ccd <= CW'(T_CCD - 1);
            else if (r_ccd != '0)                                    r_ccd <= r_ccd - 1'b1;
            if (w_issue && req_cmd == CMD_REF) r_rfc <= CW'(T_RFC - 1);
            else if (r_rfc != '0)              r_rfc <= r_rfc - 1'b1;
            if (w_issue && req_cmd == CMD_MRS) r_mrd <= CW'(T_MRD - 1);
            else if (r_mrd != '0)              r_mrd <= r_mrd - 1'b1;

            // odt window counts the cycles remaining after the current one.
            if (w_issue && req_cmd == CMD_WR) begin
                r_odt     <= 1'b1;
                r_odt_cnt <= CW'(ODT_LEN - 1);
            end else if (r_odt_cnt != '0) begin
                r_odt     <= 1'b1;
                r_odt_cnt <= r_odt_cnt - 1'b1;
            end else begin
                r_odt <= 1'b0;
            end
        end
    end

    assign cke                      = r_cke;
    assign {cs_n, ras_n, cas_n, we_n} = r_pins;
    assign a                        = r_a;
    assign ba                       = r_ba;
    assign odt                      = r_odt;
    assign err_illegal              = r_err;

endmodule

`default_nettype wire

// File: tb/tb_ddr_cmd_issuer.sv
// ============================================================================
// Module : tb_ddr_cmd_issuer
// Brief  : Directed vector bench for ddr_cmd_issuer.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_ddr_cmd_issuer;
    import ddr_cmd_pkg::*;

    logic        ck_t = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    ddr_cmd_e    req_cmd = CMD_NOP;
    logic [2:0]  req_ba = '0;
    logic [13:0] req_addr = '0;
    logic        cke, cs_n, ras_n, cas_n, we_n, odt, err_illegal;
    logic [13:0] a;
    logic [2:0]  ba;
    logic [3:0]  pins;

    ddr_cmd_issuer dut (
        .ck_t        (ck_t),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_cmd     (req_cmd),
        .req_ba      (req_ba),
        .req_addr    (req_addr),
        .cke         (cke),
        .cs_n        (cs_n),
        .ras_n       (ras_n),
        .cas_n       (cas_n),
        .we_n        (we_n),
        .a           (a),
        .ba          (ba),
        .odt         (odt),
        .err_illegal (err_illegal)
    );

    assign pins = {cs_n, ras_n, cas_n, we_n};

    always #5 ck_t = ~ck_t;

    int cyc = 0;
    always @(posedge ck_t) cyc <= cyc + 1;

    logic odt_hist [0:4095];
    always @(negedge ck_t) if (cyc < 4096) odt_hist[cyc] <= odt;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
        end
    endtask

    // Present one request, hold it until handshaken; return its pin cycle.
    task automatic send(input ddr_cmd_e cmd, input logic [2:0] b, input logic [13:0] ad,
                        output int pin_cyc, output int gap_bad, output logic timeout);
        int n;
        req_valid = 1'b1;
        req_cmd   = cmd;
        req_ba    = b;
        req_addr  = ad;
        gap_bad   = 0;
        n         = 0;
        @(negedge ck_t);
        while (!req_ready && n < 200) begin
            @(posedge ck_t); #1;
            if (pins !== PIN_NOP || err_illegal !== 1'b0) gap_bad++;
            @(negedge ck_t);
            n++;
        end
        timeout = !req_ready;
        @(posedge ck_t); #1;
        req_valid = 1'b0;
        req_cmd   = CMD_NOP;
        pin_cyc   = cyc;
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_ctl"}, {cke, pins, odt, req_ready, err_illegal}, 8'b0_1111_000);
        chk({tag, "_a_ba"}, {a, ba}, 17'h0);
    endtask

    // Called in cycle 1 after the last reset edge; returns in cycle 9.
    task automatic init_check(input string tag, output int c9);
        int bad = 0;
        for (int i = 0; i < 8; i++) begin
            if (i > 0) begin @(posedge ck_t); #1; end
            if (cke !== 1'b0 || cs_n !== 1'b1 || req_ready !== 1'b0) bad++;
        end
        chk({tag, "_cke_low_cycles"}, bad, 0);
        @(posedge ck_t); #1;
        chk({tag, "_cke_up"}, {cke, pins, req_ready}, 6'b1_0111_1);
        c9 = cyc;
    endtask

    typedef struct {
        ddr_cmd_e    cmd;
        logic [2:0]  b;
        logic [13:0] ad;
        logic [3:0]  exp_pins;
        logic        exp_err;
        int          delta;   // expected pin-cycle gap from previous row, 0 = unchecked
        logic        chk_a;
    } vec_t;

    localparam int NV = 17;
    vec_t v [NV];

    initial begin
        int pc, prev, gap, c9, q, q2, r;
        logic to;
        logic [12:0] odt_got;

        v[0]  = '{CMD_ACT, 3'd2, 14'h1A5, PIN_ACT, 1'b0, 0,  1'b1};
        v[1]  = '{CMD_RD,  3'd2, 14'h010, PIN_RD,  1'b0, 5,  1'b1};
        v[2]  = '{CMD_RD,  3'd2, 14'h020, PIN_RD,  1'b0, 4,  1'b1};
        v[3]  = '{CMD_PRE, 3'd2, 14'h000, PIN_PRE, 1'b0, 6,  1'b1};
        v[4]  = '{CMD_ACT, 3'd2, 14'h0AA, PIN_ACT, 1'b0, 5,  1'b1};
        v[5]  = '{CMD_RD,  3'd4, 14'h033, PIN_NOP, 1'b1, 1,  1'b0};
        v[6]  = '{CMD_WR,  3'd2, 14'h044, PIN_WR,  1'b0, 4,  1'b1};
        v[7]  = '{CMD_WR,  3'd2, 14'h048, PIN_WR,  1'b0, 4,  1'b1};
        v[8]  = '{CMD_PRE, 3'd0, 14'h400, PIN_PRE, 1'b0, 6,  1'b1};
        v[9]  = '{CMD_REF, 3'd0, 14'h000, PIN_REF, 1'b0, 5,  1'b0};
        v[10] = '{CMD_MRS, 3'd0, 14'h123, PIN_MRS, 1'b0, 44, 1'b1};
        v[11] = '{CMD_ACT, 3'd1, 14'h055, PIN_ACT, 1'b0, 4,  1'b1};
        v[12] = '{CMD_MRS, 3'd0, 14'h011, PIN_NOP, 1'b1, 1,  1'b0};
        v[13] = '{CMD_NOP, 3'd0, 14'h000, PIN_NOP, 1'b0, 1,  1'b0};
        v[14] = '{CMD_ACT, 3'd1, 14'h066, PIN_NOP, 1'b1, 1,  1'b0};
        v[15] = '{CMD_PRE, 3'd1, 14'h000, PIN_PRE, 1'b0, 12, 1'b1};
        v[16] = '{CMD_PRE, 3'd5, 14'h000, PIN_PRE, 1'b0, 1,  1'b1};

        repeat (3) @(posedge ck_t);
        #1;
        check_reset("reset");
        reset = 1'b0;
        init_check("init", c9);

        prev = 0;
        for (int i = 0; i < NV; i++) begin
            send(v[i].cmd, v[i].b, v[i].ad, pc, gap, to);
            chk($sformatf("v%0d_timeout", i), {31'b0, to}, 32'd0);
            chk($sformatf("v%0d_pins", i), {28'b0, pins}, {28'b0, v[i].exp_pins});
            chk($sformatf("v%0d_err", i), {31'b0, err_illegal}, {31'b0, v[i].exp_err});
            chk($sformatf("v%0d_gap_nop", i), gap, 0);
            if (v[i].delta > 0)
                chk($sformatf("v%0d_delta", i), pc - prev, v[i].delta);
            if (v[i].chk_a)
                chk($sformatf("v%0d_a_ba", i), {a, ba}, {v[i].ad, v[i].b});
            prev = pc;
        end

        // odt window: two WRs four cycles apart
        send(CMD_ACT, 3'd2, 14'h077, pc, gap, to);
        send(CMD_WR, 3'd2, 14'h008, q, gap, to);
        chk("odt_wr1_timeout", {31'b0, to}, 32'd0);
        send(CMD_WR, 3'd2, 14'h00C, q2, gap, to);
        chk("odt_wr2_delta", q2 - q, 4);
        repeat (8) @(posedge ck_t);
        #1;
        for (int k = 0; k < 13; k++) odt_got[k] = odt_hist[q - 1 + k];
        chk("odt_window", {19'b0, odt_got}, 32'h07FE);

        // reset in the middle of tRFC
        send(CMD_PRE, 3'd0, 14'h400, pc, gap, to);
        send(CMD_REF, 3'd0, 14'h000, r, gap, to);
        chk("ref_pins", {28'b0, pins}, {28'b0, PIN_REF});
        repeat (20) @(posedge ck_t);
        #1;
        chk("ref_cycle", cyc - r, 20);
        reset = 1'b1;
        @(posedge ck_t); #1;
        check_reset("midref_reset");
        reset = 1'b0;
        init_check("reinit", c9);
        send(CMD_ACT, 3'd3, 14'h0F0, pc, gap, to);
        chk("post_reset_act_latency", pc - c9, 1);
        chk("post_reset_act_pins", {28'b0, pins}, {28'b0, PIN_ACT});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
